// File: rtl/pll_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pll_pkg                                                      |
// | Description : Shared constants and state type for the fractional-N divider.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pll_pkg;

  localparam int W_DEFAULT = 8;
  localparam int DMIN      = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fnd_ratio_calc.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fnd_ratio_calc                                               |
// | Description : Candidate ratio N_INT+MC, clamped to DMIN and saturated.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fnd_ratio_calc
  import pll_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [W-1:0] i_n_int,
  input  logic         i_mc,
  output logic [W-1:0] o_dsel
);

  localparam logic [W:0] c_min = (W+1)'(DMIN);
  localparam logic [W:0] c_max = {1'b0, {W{1'b1}}};

  logic [W:0] w_sum;

  always_comb begin
    w_sum = {1'b0, i_n_int} + {{W{1'b0}}, i_mc};
    if (w_sum < c_min) begin
      o_dsel = c_min[W-1:0];
    end else if (w_sum > c_max) begin
      o_dsel = {W{1'b1}};
    end else begin
      o_dsel = w_sum[W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/frac_n_divider.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : frac_n_divider                                               |
// | Description : Dual-modulus programmable divider with seamless reload.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module frac_n_divider
  import pll_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic [W-1:0] N_INT,
  input  logic         MC,
  output logic         DIV_OUT,
  output logic         TC,
  output logic [W-1:0] RATIO
);

  localparam logic [W-1:0] c_one = {{(W-1){1'b0}}, 1'b1};

  state_t         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   ratio_q, ratio_d;
  logic           div_q, div_d;
  logic           tc_q, tc_d;
  logic           load_d;
  logic [W-1:0]   w_dsel;

  fnd_ratio_calc #(.W(W)) u_ratio_calc (
    .i_n_int (N_INT),
    .i_mc    (MC),
    .o_dsel  (w_dsel)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ratio_d = ratio_q;
    load_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (EN) begin
          load_d = 1'b1;
        end else begin
          cnt_d = '0;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (cnt_q != '0) begin
          cnt_d   = cnt_q - c_one;
          state_d = EN ? ST_RUN : ST_DRAIN;
        end else if (EN) begin
          load_d = 1'b1;
        end else begin
          // Period completes on this edge; nothing left to drain.
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (load_d) begin
      state_d = ST_RUN;
      ratio_d = w_dsel;
      cnt_d   = w_dsel - c_one;
    end

    // Outputs are precomputed from next state and registered, so they are glitch-free.
    div_d = (state_d != ST_IDLE) && (cnt_d >= (ratio_d >> 1));
    tc_d  = (state_d != ST_IDLE) && (cnt_d == '0);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ratio_q <= '0;
      div_q   <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ratio_q <= ratio_d;
      div_q   <= div_d;
      tc_q    <= tc_d;
    end
  end

  assign DIV_OUT = div_q;
  assign TC      = tc_q;
  assign RATIO   = ratio_q;

endmodule
`default_nettype wire

// File: tb/tb_frac_n_divider.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_frac_n_divider                                            |
// | Description : Self-checking bench for frac_n_divider (directed + random).  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_frac_n_divider;

  localparam int W = 8;
  localparam int RMAX = (1 << W) - 1;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         EN = 1'b0;
  logic         MC = 1'b0;
  logic [W-1:0] N_INT = '0;
  logic         DIV_OUT;
  logic         TC;
  logic [W-1:0] RATIO;

  int checks = 0;
  int errors = 0;

  // Reference model: position k within a period of length r.
  bit m_active;
  int m_r;
  int m_k;

  typedef struct {
    int n;
    int mc;
    int period;
    int high;
  } vec_t;

  vec_t vecs[8];

  frac_n_divider #(.W(W)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .EN      (EN),
    .N_INT   (N_INT),
    .MC      (MC),
    .DIV_OUT (DIV_OUT),
    .TC      (TC),
    .RATIO   (RATIO)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  function automatic int clamp_ratio(input int n, input int mc);
    int s;
    s = n + mc;
    if (s < 2) return 2;
    if (s > RMAX) return RMAX;
    return s;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_r = 0;
    m_k = 0;
  endtask

  task automatic model_load();
    m_r = clamp_ratio(int'(N_INT), int'(MC));
    m_k = 0;
    m_active = 1'b1;
  endtask

  task automatic model_step();
    if (!m_active) begin
      if (EN) model_load();
    end else if (m_k == m_r - 1) begin
      if (EN) model_load();
      else m_active = 1'b0;
    end else begin
      m_k++;
    end
  endtask

  task automatic tick();
    int exp_div;
    int exp_tc;
    @(posedge CLK);
    model_step();
    #1;
    exp_div = (m_active && (m_k < (m_r + 1) / 2)) ? 1 : 0;
    exp_tc  = (m_active && (m_k == m_r - 1)) ? 1 : 0;
    check("div_out", int'(DIV_OUT), exp_div);
    check("tc", int'(TC), exp_tc);
    check("ratio", int'(RATIO), m_r);
  endtask

  task automatic reset_dut();
    RST = 1'b1;
    model_reset();
    #3;
    check("rst_div_out", int'(DIV_OUT), 0);
    check("rst_tc", int'(TC), 0);
    check("rst_ratio", int'(RATIO), 0);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Counts cycles from the current one through the TC cycle.
  task automatic measure(output int len, output int hi);
    len = 0;
    hi = 0;
    for (int i = 0; i < 600; i++) begin
      len++;
      hi += int'(DIV_OUT);
      if (TC) break;
      tick();
    end
  endtask

  initial begin
    int len;
    int hi;
    int cyc;

    vecs[0] = '{n: 4,   mc: 0, period: 4,   high: 2};
    vecs[1] = '{n: 0,   mc: 0, period: 2,   high: 1};
    vecs[2] = '{n: 1,   mc: 1, period: 2,   high: 1};
    vecs[3] = '{n: 255, mc: 1, period: 255, high: 128};
    vecs[4] = '{n: 7,   mc: 0, period: 7,   high: 4};
    vecs[5] = '{n: 254, mc: 1, period: 255, high: 128};
    vecs[6] = '{n: 3,   mc: 1, period: 4,   high: 2};
    vecs[7] = '{n: 1,   mc: 0, period: 2,   high: 1};

    model_reset();
    #2;
    reset_dut();

    // Steady-state ratios including clamp and saturation boundaries.
    for (int v = 0; v < 8; v++) begin
      reset_dut();
      N_INT = 8'(vecs[v].n);
      MC = 1'(vecs[v].mc);
      EN = 1'b1;
      tick();
      for (int p = 0; p < 2; p++) begin
        measure(len, hi);
        check("vec_period", len, vecs[v].period);
        check("vec_high", hi, vecs[v].high);
        check("vec_ratio", int'(RATIO), vecs[v].period);
        tick();
      end
      EN = 1'b0;
    end

    // MC alternating per period: 5,4,5,4.
    reset_dut();
    N_INT = 8'd4;
    MC = 1'b1;
    EN = 1'b1;
    tick();
    for (int p = 0; p < 4; p++) begin
      measure(len, hi);
      check("alt_period", len, (p % 2 == 0) ? 5 : 4);
      check("alt_high", hi, (p % 2 == 0) ? 3 : 2);
      check("alt_ratio", int'(RATIO), (p % 2 == 0) ? 5 : 4);
      MC = ~MC;
      tick();
    end

    // EN dropped at cnt=5 of a ratio-8 period drains 6 cycles then idles.
    reset_dut();
    N_INT = 8'd8;
    MC = 1'b0;
    EN = 1'b1;
    tick();
    tick();
    tick();
    EN = 1'b0;
    measure(len, hi);
    check("drain_len", len, 6);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_div_out", int'(DIV_OUT), 0);
      check("idle_tc", int'(TC), 0);
    end

    // EN re-raised at cnt=2 in DRAIN reloads seamlessly.
    EN = 1'b1;
    tick();
    tick();
    tick();
    EN = 1'b0;
    tick();
    tick();
    tick();
    EN = 1'b1;
    measure(len, hi);
    check("redrain_rest", len, 3);
    tick();
    measure(len, hi);
    check("redrain_next", len, 8);
    check("redrain_next_high", hi, 4);

    // N_INT change mid-period affects only the next period.
    reset_dut();
    N_INT = 8'd4;
    EN = 1'b1;
    tick();
    tick();
    N_INT = 8'd7;
    measure(len, hi);
    check("nchg_rest", len, 3);
    check("nchg_ratio_cur", int'(RATIO), 4);
    tick();
    measure(len, hi);
    check("nchg_next", len, 7);
    check("nchg_ratio_next", int'(RATIO), 7);

    // Asynchronous reset between edges clears outputs immediately.
    reset_dut();
    N_INT = 8'd6;
    EN = 1'b1;
    tick();
    tick();
    tick();
    check("pre_rst_div_out", int'(DIV_OUT), 1);
    #2;
    RST = 1'b1;
    model_reset();
    #1;
    check("async_rst_div_out", int'(DIV_OUT), 0);
    check("async_rst_tc", int'(TC), 0);
    check("async_rst_ratio", int'(RATIO), 0);
    #1;
    RST = 1'b0;
    tick();
    measure(len, hi);
    check("post_rst_period", len, 6);
    check("post_rst_high", hi, 3);

    // Randomized run against the reference model.
    reset_dut();
    cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 7) == 0) N_INT = 8'($urandom_range(240, 255));
        else N_INT = 8'($urandom_range(0, 12));
      end
      EN = ($urandom_range(0, 9) != 0);
      MC = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    check("random_cycles", cyc, 3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frac_n_divider.md
FRAC_N_DIVIDER -- requirements
Module: frac_n_divider

Interface
REQ-001 SHALL have parameter W, default 8, counter and ratio width in bits.
REQ-002 SHALL have port CLK, input, 1, VCO-rate clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port EN, input, 1, run request.
REQ-005 SHALL have port N_INT, input, W, unsigned integer divide ratio.
REQ-006 SHALL have port MC, input, 1, modulus control (sigma-delta out bit); 1 adds one to the ratio.
REQ-007 SHALL have port DIV_OUT, output, 1, divided clock; also clocks the sigma-delta modulator.
REQ-008 SHALL have port TC, output, 1, terminal-count strobe, high on the last VCO cycle of each output period.
REQ-009 SHALL have port RATIO, output, W, divide ratio of the period in progress (observation).

Function
REQ-010 SHALL compute the candidate ratio Dsel = N_INT + MC in W+1 bits, clamped to a minimum of 2 and saturated to 2^W-1.
REQ-011 SHALL implement states IDLE, RUN, DRAIN, encoded as an enum.
REQ-012 IDLE with EN=1 SHALL, on the next edge, go to RUN with RATIO<=Dsel and cnt<=Dsel-1.
REQ-013 IDLE with EN=0 SHALL hold cnt=0, DIV_OUT=0, TC=0.
REQ-014 In RUN or DRAIN with cnt>0, cnt SHALL decrement by 1 per edge.
REQ-015 RUN with cnt==0 and EN=1 SHALL reload RATIO<=Dsel and cnt<=Dsel-1 on the same edge, with no idle cycle between periods.
REQ-016 RUN with EN=0 SHALL go to DRAIN on the next edge; counting continues, and the current period is never truncated.
REQ-017 DRAIN with cnt==0 SHALL go to IDLE if EN=0, and reload as in REQ-015 and go to RUN if EN=1.
REQ-018 DRAIN with cnt>0 and EN=1 SHALL return to RUN without disturbing cnt.
REQ-019 N_INT and MC SHALL be sampled only at load edges (IDLE->RUN, or cnt==0 reload); changes at any other time affect only the next period.
REQ-020 DIV_OUT SHALL be 1 in RUN or DRAIN when cnt >= RATIO>>1, and 0 otherwise, giving ceil(RATIO/2) cycles high.
REQ-021 DIV_OUT SHALL be decoded only from registered state, with no combinational path from any input, and SHALL be glitch-free.
REQ-022 TC SHALL be 1 exactly when state is not IDLE and cnt==0, decoded from registers only.
REQ-023 Output period in VCO cycles SHALL equal the RATIO loaded for that period, for every ratio from 2 to 2^W-1.

Reset
REQ-024 While RST=1, state SHALL be IDLE and cnt, RATIO, DIV_OUT, TC SHALL all be 0, immediately and independent of CLK.
REQ-025 RST asserted mid-period SHALL abandon the period; no partial pulse after release.
REQ-026 After RST falls with EN=1, the first period SHALL load on the first rising CLK edge.

Structure
REQ-027 The state enum, default W, and minimum ratio constant DMIN=2 SHALL reside in shared package pll_pkg.
REQ-028 Ratio clamp/saturate logic (REQ-010) SHALL be the single combinational sub-module fnd_ratio_calc; counter, FSM and decode stay in frac_n_divider.

Verification
REQ-029 N_INT=4, MC=0, EN=1 held: DIV_OUT period 4 (high 2, low 2), TC every 4th cycle, RATIO=4.
REQ-030 N_INT=4, MC alternating 1,0 per period: periods 5,4,5,4; DIV_OUT high 3 of 5 and 2 of 4; RATIO tracks 5,4.
REQ-031 Boundaries: N_INT=0 with MC=0 gives period 2; N_INT=1 with MC=1 gives period 2; N_INT=255 with MC=1 (W=8) gives period 255.
REQ-032 EN dropped with cnt=5, RATIO=8: 6 more cycles then IDLE, DIV_OUT=0; EN re-raised at cnt=2 in DRAIN gives seamless reload at cnt==0.
REQ-033 N_INT changed 4->7 at cnt=2: the current period stays 4, the next is 7.
REQ-034 RST pulsed asynchronously mid-period (between edges): outputs 0 before the next CLK edge; with EN=1 after release, the first edge loads a full period.
